// File: rtl/game_flow_ctrl_pkg.sv
// Shared types and constants for the game-flow controller.
//   g_state_t : top-level game phase (2-bit encoding exposed on game_state)
//   dir_t     : per-player movement direction
//   LVL_W / LIVES_W : widths of the level and lives counters
package game_flow_ctrl_pkg;

  localparam int unsigned LVL_W   = 4;
  localparam int unsigned LIVES_W = 4;

  typedef enum logic [1:0] {
    START      = 2'd0,
    PLAY       = 2'd1,
    TRANSITION = 2'd2,
    FINISH     = 2'd3
  } g_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RIGHT = 2'b01,
    LEFT  = 2'b10
  } dir_t;

endpackage

// File: rtl/game_flow_ctrl_player_dir_fsm.sv
// Registered direction tracker for one player.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   enable    : high while the game is in PLAY
//   btn_left  : left button level
//   btn_right : right button level
//   dir       : registered direction (IDLE when disabled or both/neither pressed)
module player_dir_fsm
  import game_flow_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic btn_left,
  input  logic btn_right,
  output dir_t dir
);

  dir_t dir_nxt;

  always_ff @(posedge clk) begin
    if (rst) dir <= IDLE;
    else     dir <= dir_nxt;
  end

  always_comb begin
    dir_nxt = IDLE;
    if (enable) begin
      unique case ({btn_right, btn_left})
        2'b10:   dir_nxt = RIGHT;
        2'b01:   dir_nxt = LEFT;
        default: dir_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: START -> PLAY (levels 1..NUM_LEVELS) -> FINISH,
// with a timed TRANSITION pause between levels and after a lost life.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start, level_done,
//   fail                  : single-cycle event pulses
//   btn_left, btn_right   : per-player button levels
//   game_state            : current g_state_t
//   level, lives          : current level (0 in START) and remaining lives
//   player_dir            : dir_t per player, player i at [2i+1:2i]
//   level_start           : one-cycle pulse on each entry to PLAY
//   win                   : high in FINISH after clearing the last level
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned NUM_LEVELS   = 3,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned PAUSE_CYCLES = 65_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     level_done,
  input  logic                     fail,
  input  logic [NUM_PLAYERS-1:0]   btn_left,
  input  logic [NUM_PLAYERS-1:0]   btn_right,
  output logic [1:0]               game_state,
  output logic [LVL_W-1:0]         level,
  output logic [LIVES_W-1:0]       lives,
  output logic [2*NUM_PLAYERS-1:0] player_dir,
  output logic                     level_start,
  output logic                     win
);

  localparam int unsigned CNT_W = $clog2(PAUSE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [LVL_W-1:0]   LVL_MAX   = LVL_W'(NUM_LEVELS);
  localparam logic [LIVES_W-1:0] LIVES_INI = LIVES_W'(LIVES);

  g_state_t           state, state_nxt;
  logic [LVL_W-1:0]   level_nxt;
  logic [LIVES_W-1:0] lives_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               advance, advance_nxt;
  logic               level_start_nxt, win_nxt;

  assign game_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= START;
      level       <= '0;
      lives       <= LIVES_INI;
      cnt         <= '0;
      advance     <= 1'b0;
      level_start <= 1'b0;
      win         <= 1'b0;
    end else begin
      state       <= state_nxt;
      level       <= level_nxt;
      lives       <= lives_nxt;
      cnt         <= cnt_nxt;
      advance     <= advance_nxt;
      level_start <= level_start_nxt;
      win         <= win_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    level_nxt       = level;
    lives_nxt       = lives;
    cnt_nxt         = cnt;
    advance_nxt     = advance;
    level_start_nxt = 1'b0;
    win_nxt         = win;
    unique case (state)
      START, FINISH: begin
        if (start) begin
          state_nxt       = PLAY;
          level_nxt       = LVL_W'(1);
          lives_nxt       = LIVES_INI;
          win_nxt         = 1'b0;
          level_start_nxt = 1'b1;
        end
      end
      PLAY: begin
        // fail wins over a simultaneous level_done
        if (fail) begin
          if (lives > LIVES_W'(1)) begin
            lives_nxt   = lives - LIVES_W'(1);
            state_nxt   = TRANSITION;
            cnt_nxt     = '0;
            advance_nxt = 1'b0;
          end else begin
            lives_nxt = '0;
            state_nxt = FINISH;
            win_nxt   = 1'b0;
          end
        end else if (level_done) begin
          if (level < LVL_MAX) begin
            state_nxt   = TRANSITION;
            cnt_nxt     = '0;
            advance_nxt = 1'b1;
          end else begin
            state_nxt = FINISH;
            win_nxt   = 1'b1;
          end
        end
      end
      TRANSITION: begin
        if (cnt == CNT_LAST) begin
          state_nxt       = PLAY;
          level_start_nxt = 1'b1;
          advance_nxt     = 1'b0;
          if (advance && level < LVL_MAX) level_nxt = level + LVL_W'(1);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = START;
    endcase
  end

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
    dir_t dir;
    player_dir_fsm u_dir (
      .clk       (clk),
      .rst       (rst),
      .enable    (state == PLAY),
      .btn_left  (btn_left[i]),
      .btn_right (btn_right[i]),
      .dir       (dir)
    );
    assign player_dir[2*i +: 2] = dir;
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, level_done, fail;
  logic [1:0] btn_left, btn_right;
  logic [1:0] game_state;
  logic [3:0] level, lives, player_dir;
  logic       level_start, win;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_flow_ctrl #(
    .NUM_PLAYERS  (2),
    .NUM_LEVELS   (3),
    .LIVES        (2),
    .PAUSE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .level_done  (level_done),
    .fail        (fail),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .game_state  (game_state),
    .level       (level),
    .lives       (lives),
    .player_dir  (player_dir),
    .level_start (level_start),
    .win         (win)
  );

  typedef struct {
    logic       rst, start, ld, fail;
    logic [1:0] bl, br;
    logic [1:0] st;
    logic [3:0] lvl, lv, dir;
    logic       ls, w;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, s, ld, f, input logic [1:0] bl, br,
                     input logic [1:0] st, input logic [3:0] lvl, lv, dir,
                     input logic ls, w);
    vec_t v;
    v.rst = r; v.start = s; v.ld = ld; v.fail = f; v.bl = bl; v.br = br;
    v.st = st; v.lvl = lvl; v.lv = lv; v.dir = dir; v.ls = ls; v.w = w;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, s, ld, f, input logic [1:0] bl, br);
    @(negedge clk);
    rst = r; start = s; level_done = ld; fail = f; btn_left = bl; btn_right = br;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] st, input logic [3:0] lvl, lv, dir,
                       input logic ls, w);
    tests++;
    if (game_state !== st || level !== lvl || lives !== lv || player_dir !== dir ||
        level_start !== ls || win !== w) begin
      errors++;
      $display("FAIL %s: got st=%0d lvl=%0d lives=%0d dir=%b ls=%b win=%b, expected st=%0d lvl=%0d lives=%0d dir=%b ls=%b win=%b",
               name, game_state, level, lives, player_dir, level_start, win,
               st, lvl, lv, dir, ls, w);
    end
  endtask

  localparam logic [1:0] S = 2'd0, P = 2'd1, T = 2'd2, F = 2'd3;

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; level_done = 1'b0; fail = 1'b0;
    btn_left = '0; btn_right = '0;

    //  rst st ld fl  bl     br       state lvl lives dir     ls win
    add(1, 0, 0, 0, 2'b00, 2'b00,   S, 0, 2, 4'b0000, 0, 0); // reset
    add(0, 0, 0, 0, 2'b10, 2'b11,   S, 0, 2, 4'b0000, 0, 0); // buttons ignored in START
    add(0, 1, 0, 0, 2'b10, 2'b11,   P, 1, 2, 4'b0000, 1, 0); // start
    add(0, 0, 0, 0, 2'b10, 2'b11,   P, 1, 2, 4'b0001, 0, 0); // P0 right, P1 both
    add(0, 0, 1, 0, 2'b10, 2'b11,   T, 1, 2, 4'b0001, 0, 0); // level_done
    add(0, 1, 0, 0, 2'b10, 2'b11,   T, 1, 2, 4'b0000, 0, 0); // start ignored, dirs idle
    add(0, 0, 0, 1, 2'b10, 2'b11,   T, 1, 2, 4'b0000, 0, 0); // fail ignored
    add(0, 0, 1, 0, 2'b10, 2'b11,   T, 1, 2, 4'b0000, 0, 0); // level_done ignored
    add(0, 0, 0, 0, 2'b00, 2'b00,   P, 2, 2, 4'b0000, 1, 0); // exit after 4 cycles
    add(0, 0, 0, 0, 2'b00, 2'b00,   P, 2, 2, 4'b0000, 0, 0);
    add(0, 0, 0, 1, 2'b00, 2'b00,   T, 2, 1, 4'b0000, 0, 0); // fail at level 2
    add(0, 0, 0, 0, 2'b00, 2'b00,   T, 2, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   T, 2, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   T, 2, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   P, 2, 1, 4'b0000, 1, 0); // replay level 2
    add(0, 0, 0, 1, 2'b00, 2'b00,   F, 2, 0, 4'b0000, 0, 0); // last life lost
    add(0, 0, 0, 0, 2'b00, 2'b00,   F, 2, 0, 4'b0000, 0, 0);
    add(0, 0, 1, 0, 2'b00, 2'b00,   F, 2, 0, 4'b0000, 0, 0); // level_done ignored in FINISH
    add(0, 1, 0, 0, 2'b00, 2'b00,   P, 1, 2, 4'b0000, 1, 0); // restart from FINISH
    add(0, 0, 1, 1, 2'b00, 2'b00,   T, 1, 1, 4'b0000, 0, 0); // fail beats level_done
    add(0, 0, 0, 0, 2'b00, 2'b00,   T, 1, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   T, 1, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   T, 1, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   P, 1, 1, 4'b0000, 1, 0); // level stays 1
    add(0, 0, 1, 0, 2'b00, 2'b00,   T, 1, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   T, 1, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   T, 1, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   T, 1, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   P, 2, 1, 4'b0000, 1, 0);
    add(0, 0, 1, 0, 2'b00, 2'b00,   T, 2, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   T, 2, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   T, 2, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   T, 2, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   P, 3, 1, 4'b0000, 1, 0);
    add(0, 0, 1, 0, 2'b00, 2'b00,   F, 3, 1, 4'b0000, 0, 1); // last level cleared
    add(0, 0, 0, 0, 2'b00, 2'b00,   F, 3, 1, 4'b0000, 0, 1); // FINISH holds
    add(0, 1, 0, 0, 2'b00, 2'b00,   P, 1, 2, 4'b0000, 1, 0); // new game clears win
    add(0, 0, 1, 0, 2'b00, 2'b00,   T, 1, 2, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   T, 1, 2, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   T, 1, 2, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   T, 1, 2, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   P, 2, 2, 4'b0000, 1, 0);
    add(0, 0, 1, 0, 2'b00, 2'b00,   T, 2, 2, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b00,   T, 2, 2, 4'b0000, 0, 0);
    add(1, 0, 0, 0, 2'b11, 2'b00,   S, 0, 2, 4'b0000, 0, 0); // reset mid-TRANSITION
    add(0, 0, 0, 0, 2'b00, 2'b00,   S, 0, 2, 4'b0000, 0, 0);
    add(0, 1, 0, 0, 2'b01, 2'b00,   P, 1, 2, 4'b0000, 1, 0); // resume at level 1
    add(0, 0, 0, 0, 2'b01, 2'b00,   P, 1, 2, 4'b0010, 0, 0); // P0 left only
    add(0, 0, 0, 0, 2'b00, 2'b11,   P, 1, 2, 4'b0101, 0, 0); // both players right

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].ld, vecs[i].fail, vecs[i].bl, vecs[i].br);
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].lvl, vecs[i].lv, vecs[i].dir,
            vecs[i].ls, vecs[i].w);
    end

    // Pause length measured independently: count TRANSITION cycles until PLAY returns.
    drive(0, 0, 1, 0, 2'b00, 2'b00);
    n = 0;
    while (game_state == T && n < 20) begin
      n++;
      drive(0, 0, 0, 0, 2'b00, 2'b00);
    end
    tests++;
    if (n != 4) begin
      errors++;
      $display("FAIL pause_len: got %0d cycles, expected 4", n);
    end
    check("after_pause", P, 2, 2, 4'b0000, 1, 0);
    drive(0, 0, 0, 0, 2'b00, 2'b00);
    check("ls_one_cycle", P, 2, 2, 4'b0000, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Parametrised game-flow controller; successor to the fixed two-player, single-level state set.
- Sequences START -> PLAY (levels 1..NUM_LEVELS) -> FINISH, with a timed TRANSITION pause between levels and after a life is lost.
- Tracks lives and derives a registered IDLE/RIGHT/LEFT direction for each of NUM_PLAYERS players from button inputs.
- Sits between input/debounce logic and the draw/physics blocks.

Parameters:
- NUM_PLAYERS, 2, number of independent players (1..8).
- NUM_LEVELS, 3, number of levels before a win (1..15).
- LIVES, 3, lives at game start (1..15).
- PAUSE_CYCLES, 65_000_000, clock cycles spent in TRANSITION (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a game from START or FINISH.
- level_done  in  1  single-cycle pulse; current level cleared.
- fail  in  1  single-cycle pulse; a player died.
- btn_left  in  NUM_PLAYERS  per-player left button, level.
- btn_right  in  NUM_PLAYERS  per-player right button, level.
- game_state  out  2  g_state_t encoding.
- level  out  4  current level: 0 in START, 1..NUM_LEVELS otherwise.
- lives  out  4  remaining lives.
- player_dir  out  2*NUM_PLAYERS  dir_t per player; player i occupies bits [2i+1:2i].
- level_start  out  1  one-cycle pulse on each entry to PLAY.
- win  out  1  high in FINISH when all levels were cleared; low otherwise.

Behaviour:
- Reset (sync, rst=1 at a clk edge): game_state=START, level=0, lives=LIVES, player_dir all IDLE, level_start=0, win=0, pause counter=0. Reset mid-game aborts immediately.
- All outputs are registered; each state change is visible 1 cycle after the triggering input edge.
- START:
  - start -> PLAY; level=1, lives=LIVES, level_start=1 for 1 cycle.
  - All other inputs ignored.
- PLAY:
  - fail has priority over level_done when both arrive in the same cycle.
  - fail with lives>1 -> lives-1, go to TRANSITION; level is unchanged (replay).
  - fail with lives==1 -> lives=0, go to FINISH with win=0.
  - level_done with level<NUM_LEVELS -> TRANSITION; level+1 is applied on exit from TRANSITION.
  - level_done with level==NUM_LEVELS -> FINISH with win=1.
  - start is ignored in PLAY.
- TRANSITION:
  - Counter loads 0 on entry and increments each cycle.
  - When counter==PAUSE_CYCLES-1 -> PLAY and level_start=1. Residency is exactly PAUSE_CYCLES cycles.
  - Level increments on that exit only if entry was via level_done (a pending-advance flag is registered on entry).
  - start, fail and level_done are ignored.
- FINISH:
  - Holds level, lives and win.
  - start -> PLAY at level=1, lives=LIVES, win=0, level_start=1.
- Directions, per player, updated every cycle:
  - Outside PLAY: IDLE.
  - In PLAY: right only -> RIGHT; left only -> LEFT; both or neither -> IDLE.
  - Value is registered, so latency is 1 cycle from the button.
- Counter width is $clog2(PAUSE_CYCLES+1). No wrap is possible.
- level and lives saturate and never wrap.

Decomposition:
- Shared package (extends the existing state package):
  - g_state_t {START, PLAY, TRANSITION, FINISH} as 2 bits.
  - dir_t {IDLE=2'b00, RIGHT=2'b01, LEFT=2'b10}.
  - Constants LVL_W=4 and LIVES_W=4.
- Sub-module player_dir_fsm: one instance per player via generate. Inputs clk, rst, enable, btn_left, btn_right; output dir_t.

Test Plan (NUM_PLAYERS=2, NUM_LEVELS=3, LIVES=2, PAUSE_CYCLES=4):
- Reset, then start -> next cycle game_state=PLAY, level=1, lives=2, level_start high for exactly 1 cycle.
- In PLAY, level_done -> TRANSITION for exactly 4 cycles, then PLAY with level=2 and one level_start pulse. Repeat through level 3; level_done -> FINISH, win=1, level stays 3.
- fail at level 2 -> lives=1, TRANSITION, then PLAY at level=2. Second fail -> FINISH, win=0, lives=0.
- fail and level_done in the same cycle at level 1, lives 2 -> lives=1, level stays 1 after the pause.
- P0 right=1, P1 left=1 and right=1 -> player_dir=4'b0001. Same buttons in START/TRANSITION -> 4'b0000. Pulse start, fail or level_done during TRANSITION -> no effect.
- rst asserted mid-TRANSITION at level 2 -> next cycle START, level=0, lives=2, all dirs IDLE. A subsequent start resumes at level 1.
